// File: rtl/axi_id_serializer_if.sv
// AXI channel bundle shared by the ID-ful upstream and ID-less downstream sides.
// ID, address, data and user widths are per-instance parameters.
interface axi_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_id_serializer.sv
// ID FIFO: holds request IDs in issue order; head is a plain register read.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is dropped while full, pop is dropped while empty (no underflow).
module axi_id_serializer_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_full     = (r_cnt == FULL_CNT);
  assign o_empty    = (r_cnt == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Re-tags in-order B/R responses of an ID-less slave with the upstream AW/AR IDs.
// Latency: zero on every channel; only the registered ID head is muxed onto B/R.
// Backpressure: AW/AR stall while 2**DEPTH_LOG2 IDs are outstanding. Checks: AXI_ID_SERIALIZER_ASSERT_EN.
module axi_id_serializer #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic       clk,
  input logic       rstn,
  axi_channel.slave  master,
  axi_channel.master slave
);
  localparam int M = $bits(master.aw_id);

  if (($bits(master.w_data)  != $bits(slave.w_data))  ||
      ($bits(master.aw_addr) != $bits(slave.aw_addr)) ||
      ($bits(master.aw_user) != $bits(slave.aw_user)) ||
      ($bits(master.w_user)  != $bits(slave.w_user))  ||
      ($bits(master.b_user)  != $bits(slave.b_user))  ||
      ($bits(master.ar_user) != $bits(slave.ar_user)) ||
      ($bits(master.r_user)  != $bits(slave.r_user))) begin : g_width_mismatch
    $fatal(1, "axi_id_serializer: master/slave data, address or user widths differ");
  end

  logic         w_aw_full;
  logic         w_aw_empty;
  logic         w_aw_push;
  logic         w_b_pop;
  logic [M-1:0] w_b_head;
  logic         w_ar_full;
  logic         w_ar_empty;
  logic         w_ar_push;
  logic         w_r_pop;
  logic [M-1:0] w_r_head;
  logic         w_unused_ids;

  // Downstream has no ID; its returned IDs are ignored in the datapath.
  assign w_unused_ids = ^{slave.b_id, slave.r_id};

  assign slave.aw_id    = '0;
  assign slave.aw_addr  = master.aw_addr;
  assign slave.aw_len   = master.aw_len;
  assign slave.aw_size  = master.aw_size;
  assign slave.aw_burst = master.aw_burst;
  assign slave.aw_user  = master.aw_user;
  assign slave.aw_valid = master.aw_valid && !w_aw_full;
  assign master.aw_ready = slave.aw_ready && !w_aw_full;
  assign w_aw_push      = slave.aw_valid && slave.aw_ready;

  assign slave.w_data   = master.w_data;
  assign slave.w_strb   = master.w_strb;
  assign slave.w_last   = master.w_last;
  assign slave.w_user   = master.w_user;
  assign slave.w_valid  = master.w_valid;
  assign master.w_ready = slave.w_ready;

  assign master.b_id    = w_b_head;
  assign master.b_resp  = slave.b_resp;
  assign master.b_user  = slave.b_user;
  assign master.b_valid = slave.b_valid;
  assign slave.b_ready  = master.b_ready;
  assign w_b_pop        = slave.b_valid && slave.b_ready;

  assign slave.ar_id    = '0;
  assign slave.ar_addr  = master.ar_addr;
  assign slave.ar_len   = master.ar_len;
  assign slave.ar_size  = master.ar_size;
  assign slave.ar_burst = master.ar_burst;
  assign slave.ar_user  = master.ar_user;
  assign slave.ar_valid = master.ar_valid && !w_ar_full;
  assign master.ar_ready = slave.ar_ready && !w_ar_full;
  assign w_ar_push      = slave.ar_valid && slave.ar_ready;

  // A read ID retires only with the final beat of its burst.
  assign master.r_id    = w_r_head;
  assign master.r_data  = slave.r_data;
  assign master.r_resp  = slave.r_resp;
  assign master.r_last  = slave.r_last;
  assign master.r_user  = slave.r_user;
  assign master.r_valid = slave.r_valid;
  assign slave.r_ready  = master.r_ready;
  assign w_r_pop        = slave.r_valid && slave.r_ready && slave.r_last;

  axi_id_serializer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(M)) u_aw_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_aw_push),
    .i_push_dat (master.aw_id),
    .i_pop      (w_b_pop),
    .o_head_dat (w_b_head),
    .o_full     (w_aw_full),
    .o_empty    (w_aw_empty)
  );

  axi_id_serializer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(M)) u_ar_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_ar_push),
    .i_push_dat (master.ar_id),
    .i_pop      (w_r_pop),
    .o_head_dat (w_r_head),
    .o_full     (w_ar_full),
    .o_empty    (w_ar_empty)
  );

`ifdef AXI_ID_SERIALIZER_ASSERT_EN
  logic r_aw_wait;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_wait <= 1'b0;
    end else begin
      r_aw_wait <= master.aw_valid && !master.aw_ready;
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (slave.b_valid && w_aw_empty) $error("axi_id_serializer: B response with no outstanding write");
      if (slave.r_valid && w_ar_empty) $error("axi_id_serializer: R response with no outstanding read");
      if (slave.b_valid && (slave.b_id != '0)) $error("axi_id_serializer: downstream b_id is not 0");
      if (slave.r_valid && (slave.r_id != '0)) $error("axi_id_serializer: downstream r_id is not 0");
      if (r_aw_wait && !master.aw_valid) $error("axi_id_serializer: aw_valid dropped before handshake");
    end
  end
`else
  logic w_unused_empty;
  assign w_unused_empty = w_aw_empty ^ w_ar_empty;
`endif
endmodule
